// File: rtl/edit_seq.sv
// edit_seq: clock-setting edit sequencer with field select, blink enables and auto-repeat increment.
// Optional EDIT_SEC_EN macro adds the seconds field; without it only hours and minutes are editable.
module edit_seq #(
  parameter int TIMEOUT  = 250000000,
  parameter int HOLD_DLY = 25000000,
  parameter int REP_PER  = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_p,
  input  logic       next_p,
  input  logic       inc_lvl,
  output logic [2:0] blink_on,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       inc_sec,
  output logic       editing
);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int HW = $clog2(HOLD_DLY + 1);
  localparam int RW = $clog2(REP_PER + 1);
`ifdef EDIT_SEC_EN
  typedef enum logic [1:0] {IDLE, E_HOUR, E_MIN, E_SEC} state_t;
`else
  typedef enum logic [1:0] {IDLE, E_HOUR, E_MIN} state_t;
`endif
  state_t state, nxt, adv;
  logic [IW-1:0] idle_cnt, idle_d;
  logic [HW-1:0] hold, hold_d;
  logic [RW-1:0] rep, rep_d;
  logic [2:0] fld, fld_d, inc_q;
  logic prev, act, act_d, edit, tmo, chg, start, keep, sat, fire;

  function automatic logic [2:0] field(state_t s);
`ifdef EDIT_SEC_EN
    return {s == E_HOUR, s == E_MIN, s == E_SEC};
`else
    return {s == E_HOUR, s == E_MIN, 1'b0};
`endif
  endfunction

  always_comb begin
    edit = state != IDLE;
    tmo = edit && idle_cnt == IW'(TIMEOUT - 1);
`ifdef EDIT_SEC_EN
    adv = state == E_HOUR ? E_MIN : state == E_MIN ? E_SEC : E_HOUR;
`else
    adv = state == E_HOUR ? E_MIN : E_HOUR;
`endif
    nxt = mode_p ? (edit ? IDLE : E_HOUR) : tmo ? IDLE : (next_p && edit) ? adv : state;
    chg = nxt != state;
    // prev always tracks the last sampled level, so a press held across a field change never looks like an edge
    start = edit && !chg && inc_lvl && !prev;
    keep = act && !chg && inc_lvl;
    sat = hold == HW'(HOLD_DLY);
    fire = start || (keep && sat && rep == '0);
    hold_d = start ? HW'(1) : keep ? (sat ? hold : hold + HW'(1)) : '0;
    rep_d = (keep && sat) ? (rep == '0 ? RW'(REP_PER - 1) : rep - RW'(1)) : '0;
    act_d = start || keep;
    idle_d = (nxt == IDLE || mode_p || next_p || inc_lvl) ? '0 : idle_cnt + IW'(1);
    fld = field(state);
    fld_d = field(nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idle_cnt <= '0;
      hold <= '0;
      rep <= '0;
      act <= 1'b0;
      prev <= 1'b1;
      inc_q <= '0;
      blink_on <= '0;
      editing <= 1'b0;
    end else begin
      state <= nxt;
      idle_cnt <= idle_d;
      hold <= hold_d;
      rep <= rep_d;
      act <= act_d;
      prev <= inc_lvl;
      inc_q <= fire ? fld : 3'b000;
      blink_on <= fld_d;
      editing <= nxt != IDLE;
    end
  end

  assign {inc_hour, inc_min, inc_sec} = inc_q;
endmodule

// File: tb/tb_edit_seq.sv
// tb_edit_seq: randomized and directed bench for edit_seq against a press-count behavioural model.
module tb_edit_seq;
  localparam int TIMEOUT = 20;
  localparam int HOLD_DLY = 8;
  localparam int REP_PER = 4;
`ifdef EDIT_SEC_EN
  localparam bit SEC = 1'b1;
`else
  localparam bit SEC = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, mode_p = 1'b0, next_p = 1'b0, inc_lvl = 1'b0;
  logic [2:0] blink_on;
  logic inc_hour, inc_min, inc_sec, editing;
  int checks = 0, failures = 0;
  int st = 0, n = 0, idle = 0;
  bit prev = 1'b1, pulse = 1'b0;
  bit seen_sec_blink = 1'b0;

  edit_seq #(.TIMEOUT(TIMEOUT), .HOLD_DLY(HOLD_DLY), .REP_PER(REP_PER)) dut (
    .clk(clk), .rst(rst), .mode_p(mode_p), .next_p(next_p), .inc_lvl(inc_lvl),
    .blink_on(blink_on), .inc_hour(inc_hour), .inc_min(inc_min), .inc_sec(inc_sec),
    .editing(editing)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, int obs, int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int fbits(int s);
    return s == 1 ? 4 : s == 2 ? 2 : s == 3 ? 1 : 0;
  endfunction

  task automatic model_reset();
    st = 0; n = 0; idle = 0; prev = 1'b1; pulse = 1'b0;
  endtask

  // One clock: drive inputs at negedge, advance the model at posedge, compare just after.
  task automatic step(bit m, bit nx, bit l);
    int nst;
    bit edit, tmo;
    @(negedge clk);
    mode_p = m; next_p = nx; inc_lvl = l;
    @(posedge clk);
    edit = st != 0;
    tmo = edit && idle == TIMEOUT - 1;
    nst = m ? (edit ? 0 : 1) : tmo ? 0 : (nx && edit) ? (st == 1 ? 2 : (st == 2 && SEC) ? 3 : 1) : st;
    if (nst != st || !l) n = 0;
    else if (n > 0) n++;
    else if (!prev && edit) n = 1;
    pulse = n == 1 || (n > HOLD_DLY && (n - 1 - HOLD_DLY) % REP_PER == 0);
    idle = (nst == 0 || m || nx || l) ? 0 : idle + 1;
    prev = l;
    st = nst;
    #1;
    if (blink_on[0]) seen_sec_blink = 1'b1;
    check("blink_on", blink_on, fbits(st));
    check("inc", {inc_hour, inc_min, inc_sec}, pulse ? fbits(st) : 0);
    check("editing", editing, st != 0);
  endtask

  initial begin
    #2;
    check("rst_blink", blink_on, 0);
    check("rst_inc", {inc_hour, inc_min, inc_sec}, 0);
    check("rst_editing", editing, 0);
    @(negedge clk); rst = 1'b0;
    model_reset();
    // field cycling
    step(1, 0, 0);
    check("enter_hour", blink_on, 3'b100);
    step(0, 1, 0);
    check("next_min", blink_on, 3'b010);
    step(0, 1, 0);
    check("next_third", blink_on, SEC ? 3'b001 : 3'b100);
    if (SEC) step(0, 1, 0);
    check("wrap_hour", blink_on, 3'b100);
    check("still_editing", editing, 1);
    // auto-repeat in E_MIN: hold 20 cycles, then release
    step(0, 1, 0);
    for (int i = 1; i <= 20; i++) begin
      step(0, 0, 1);
      check("rep_min_pulse", inc_min, (i == 1 || i == 9 || i == 13 || i == 17));
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0);
    // timeout, pushed back by a press at cycle 15
    step(1, 0, 0);
    step(1, 0, 0);
    for (int i = 1; i <= 14; i++) step(0, 0, 0);
    step(0, 0, 1);
    for (int i = 1; i <= 19; i++) step(0, 0, 0);
    check("timeout_not_yet", editing, 1);
    step(0, 0, 0);
    check("timeout_exit", editing, 0);
    check("timeout_blink", blink_on, 0);
    // simultaneous mode/next/inc edge on the last field
    step(1, 0, 0);
    step(0, 1, 0);
    if (SEC) step(0, 1, 0);
    step(1, 1, 1);
    check("simul_idle", editing, 0);
    check("simul_noinc", {inc_hour, inc_min, inc_sec}, 0);
    step(0, 0, 0);
    // async reset during a held repeat
    step(1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_blink", blink_on, 0);
    check("arst_inc", {inc_hour, inc_min, inc_sec}, 0);
    check("arst_editing", editing, 0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    step(1, 0, 1);
    for (int i = 0; i < 12; i++) step(0, 0, 1);
    step(0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit l;
      l = ($urandom_range(0, 99) < 12) ? ~inc_lvl : inc_lvl;
      step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 6, l);
    end
    if (!SEC) check("no_sec_blink", seen_sec_blink, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/edit_seq.md
EDIT_SEQ -- requirements
Module: edit_seq

Interface
REQ-001 Parameter TIMEOUT, default 250000000: idle clock cycles with no button activity before edit mode is abandoned.
REQ-002 Parameter HOLD_DLY, default 25000000: cycles inc_lvl must be held before auto-repeat starts.
REQ-003 Parameter REP_PER, default 5000000: cycles between auto-repeat increment pulses.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 mode_p  in  1  debounced single-cycle pulse; enter or leave edit mode.
REQ-007 next_p  in  1  debounced single-cycle pulse; advance to the next field.
REQ-008 inc_lvl  in  1  debounced, synchronized level of the increment button.
REQ-009 blink_on  out  3  per-field blink enable {hour, min, sec}, one-hot or zero; drives the on input of each field's blinker.
REQ-010 inc_hour, inc_min, inc_sec  out  1 each  single-cycle increment pulses to the time counters.
REQ-011 editing  out  1  high in any edit state.

Function
REQ-012 The FSM SHALL have states IDLE, E_HOUR, E_MIN, E_SEC.
REQ-013 IDLE + mode_p -> E_HOUR; any edit state + mode_p -> IDLE.
REQ-014 next_p SHALL advance E_HOUR -> E_MIN -> E_SEC -> E_HOUR; next_p in IDLE is ignored.
REQ-015 blink_on SHALL be 3'b100 in E_HOUR, 3'b010 in E_MIN, 3'b001 in E_SEC, and 3'b000 in IDLE, registered and valid in the same cycle as the state.
REQ-016 A rising edge of inc_lvl in an edit state SHALL produce exactly one pulse on the current field's inc output in the cycle after the edge is sampled.
REQ-017 Once inc_lvl has been held high for HOLD_DLY cycles after the edge, a further pulse SHALL be issued, followed by one every REP_PER cycles while inc_lvl stays high.
REQ-018 Releasing inc_lvl SHALL stop repeat immediately and clear the hold and repeat counters.
REQ-019 At most one inc_* output SHALL be high in any cycle, and none SHALL be high in IDLE.
REQ-020 The idle counter SHALL clear on mode_p, next_p or inc_lvl high, and increment otherwise while editing.
REQ-021 When the idle counter reaches TIMEOUT-1, the FSM SHALL go to IDLE on the next edge.
REQ-022 The idle counter SHALL hold at 0 in IDLE.
REQ-023 Priority in the same cycle SHALL be mode_p > next_p > increment.
REQ-024 A state change (mode_p or next_p) SHALL suppress any inc pulse in that cycle and restart the inc edge/hold logic.
REQ-025 An inc_lvl still held across a field change SHALL NOT pulse until it is released and pressed again.
REQ-026 Counter widths SHALL be sized from the parameters, and no counter SHALL wrap during a held press; the hold counter saturates.

Reset
REQ-027 Asserting rst SHALL force IDLE, blink_on=0, all inc_*=0, editing=0, and all counters=0 immediately, regardless of the clock.
REQ-028 Reset asserted mid-edit or mid-repeat SHALL abandon the edit with no further pulses.
REQ-029 After rst deasserts, inc_lvl already high SHALL NOT be treated as a rising edge.

Configuration
REQ-030 Macro EDIT_SEC_EN: when defined, E_SEC exists as specified.
REQ-031 When EDIT_SEC_EN is undefined:
  - E_SEC is removed and next_p cycles E_HOUR <-> E_MIN.
  - blink_on[0] and inc_sec are tied to 0.
  - Port widths are unchanged.

Verification (TIMEOUT=20, HOLD_DLY=8, REP_PER=4)
REQ-032 Field cycling: rst, mode_p, then next_p x3 -> blink_on goes 100, 010, 001, 100, with editing=1 throughout.
REQ-033 Auto-repeat: in E_MIN, hold inc_lvl for 20 cycles -> inc_min pulses at cycles 1, 9, 13 and 17 after the edge, inc_hour and inc_sec stay 0, and no pulse follows release.
REQ-034 Timeout: in E_HOUR with no input for 20 cycles -> state is IDLE and blink_on=000; one input at cycle 15 pushes the exit back 20 cycles.
REQ-035 Simultaneous inputs: mode_p, next_p and an inc_lvl edge in the same cycle while in E_SEC -> IDLE with no inc pulse.
REQ-036 Reset mid-repeat: assert rst during a held inc -> all outputs 0 immediately; after release, with inc_lvl still high, no pulse occurs.
REQ-037 Without EDIT_SEC_EN: next_p x2 from E_HOUR -> 010, then 100, and blink_on[0] never becomes 1.
